// File: rtl/ro_readout_scanner.sv
// ro_readout_scanner
// Initiator side of the region readout interface. Walks every address of
// every ring-oscillator / SoC readout region in order. Each address is held
// on its region's address port until the data has settled, then the region
// data is sampled and emitted as one tagged word {region, addr, data} on a
// valid/ready stream.
//
// Optional feature: define RO_READOUT_SKIP_ZERO_EN to silently skip entries
// whose sampled data is all zero (dead or unstarted oscillators).
//
// state  | meaning
// IDLE   | waiting for start_i; all outputs quiet
// SETTLE | address driven to the selected region, waiting for data to settle
// SEND   | captured word presented on the stream, waiting for handshake

module ro_readout_scanner #(
    parameter int NUM_REGIONS = 17,
    parameter int NUM_ADDR    = 10,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 24,
    parameter int SETTLE_CYC  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          abort_i,
    output logic [NUM_REGIONS*ADDR_W-1:0] addr_o,
    input  logic [NUM_REGIONS*DATA_W-1:0] data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [10+DATA_W-1:0]          out_data_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

`ifdef RO_READOUT_SKIP_ZERO_EN
    localparam logic SKIP_ZERO = 1'b1;
`else
    localparam logic SKIP_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t                          r_state;
    logic [4:0]                      r_rgn;
    logic [4:0]                      r_adr;
    logic [CNT_W-1:0]                r_cnt;
    logic [NUM_REGIONS*ADDR_W-1:0]   r_addr;
    logic                            r_valid;
    logic [10+DATA_W-1:0]            r_data;
    logic                            r_busy;
    logic                            r_done;

    logic [DATA_W-1:0]               w_data_sel;
    logic                            w_last_rgn;
    logic                            w_last_adr;
    logic                            w_last;
    logic [4:0]                      w_nxt_rgn;
    logic [4:0]                      w_nxt_adr;
    logic                            w_settled;
    logic                            w_skip;

    // Address bus image with only the selected region driven, others at zero.
    function automatic logic [NUM_REGIONS*ADDR_W-1:0] f_addr(input logic [4:0] rgn,
                                                             input logic [4:0] adr);
        logic [NUM_REGIONS*ADDR_W-1:0] v;
        v = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (rgn == 5'(r)) begin
                v[r*ADDR_W +: ADDR_W] = ADDR_W'(adr);
            end
        end
        return v;
    endfunction

    // Select the data slice of the region currently being read.
    always_comb begin
        w_data_sel = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (r_rgn == 5'(r)) begin
                w_data_sel = data_i[r*DATA_W +: DATA_W];
            end
        end
    end

    // Sweep position bookkeeping: last-entry detection and next entry in order.
    always_comb begin
        w_last_rgn = (r_rgn == 5'(NUM_REGIONS - 1));
        w_last_adr = (r_adr == 5'(NUM_ADDR - 1));
        w_last     = w_last_rgn && w_last_adr;
        if (w_last_adr) begin
            w_nxt_adr = 5'd0;
            w_nxt_rgn = r_rgn + 5'd1;
        end else begin
            w_nxt_adr = r_adr + 5'd1;
            w_nxt_rgn = r_rgn;
        end
        w_settled = (r_cnt == CNT_W'(SETTLE_CYC));
        w_skip    = SKIP_ZERO && (w_data_sel == '0);
    end

    // Scanner FSM with registered outputs. The settle counter starts at 0 on
    // start (one extra setup cycle for the first entry) and at 1 after each
    // handshake, so the address is always held at least SETTLE_CYC cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rgn   <= '0;
            r_adr   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= SETTLE;
                        r_rgn   <= '0;
                        r_adr   <= '0;
                        r_cnt   <= '0;
                        r_addr  <= f_addr(5'd0, 5'd0);
                        r_busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_addr  <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_settled) begin
                        if (w_skip) begin
                            if (w_last) begin
                                r_state <= IDLE;
                                r_addr  <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_rgn  <= w_nxt_rgn;
                                r_adr  <= w_nxt_adr;
                                r_cnt  <= CNT_W'(1);
                                r_addr <= f_addr(w_nxt_rgn, w_nxt_adr);
                            end
                        end else begin
                            r_data  <= {r_rgn, r_adr, w_data_sel};
                            r_valid <= 1'b1;
                            r_state <= SEND;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SEND: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_addr  <= '0;
                        r_busy  <= 1'b0;
                    end else if (out_ready_i) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= IDLE;
                            r_addr  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SETTLE;
                            r_rgn   <= w_nxt_rgn;
                            r_adr   <= w_nxt_adr;
                            r_cnt   <= CNT_W'(1);
                            r_addr  <= f_addr(w_nxt_rgn, w_nxt_adr);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_addr  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_o      = r_addr;
    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule

// File: tb/tb_ro_readout_scanner.sv
// Testbench for ro_readout_scanner: scoreboard of expected tagged words,
// region data generated from the scanner's own address outputs.

module tb_ro_readout_scanner;

    localparam int NR = 17;
    localparam int NA = 10;
    localparam int AW = 5;
    localparam int DW = 24;
    localparam int OW = 10 + DW;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic             abort_i;
    logic [NR*AW-1:0] addr_o;
    logic [NR*DW-1:0] data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [OW-1:0]    out_data_o;
    logic             busy_o;
    logic             done_o;

    logic [NR-1:0]    zero_mask;
    logic [OW-1:0]    exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_words = 0;
    int n_done  = 0;
    int cyc     = 0;
    int last_hs = -1;
    logic chk_spacing = 1'b0;

    logic          prev_valid = 1'b0;
    logic          prev_hs    = 1'b0;
    logic          prev_kill  = 1'b0;
    logic [OW-1:0] prev_data  = '0;

    ro_readout_scanner #(
        .NUM_REGIONS(NR), .NUM_ADDR(NA), .ADDR_W(AW), .DATA_W(DW), .SETTLE_CYC(2)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .addr_o(addr_o), .data_i(data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] f_data(input int r, input int a);
        return {8'h5A, 3'b000, 5'(r), 3'b000, 5'(a)};
    endfunction

    function automatic logic [OW-1:0] f_word(input int r, input int a, input logic z);
        return {5'(r), 5'(a), z ? {DW{1'b0}} : f_data(r, a)};
    endfunction

    // Region model: each region answers its own address with a tagged pattern.
    always_comb begin
        data_i = '0;
        for (int r = 0; r < NR; r++) begin
            data_i[r*DW +: DW] = zero_mask[r] ? {DW{1'b0}} : f_data(r, int'(addr_o[r*AW +: AW]));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: scoreboard pop on handshake, hold/stability while stalled.
    always @(negedge clk) begin
        logic hs;
        hs = !rst && !abort_i && out_valid_o && out_ready_i;
        if (!rst && prev_valid && !prev_hs && !prev_kill) begin
            check("valid_held", 64'(out_valid_o), 64'd1);
            if (out_valid_o) check("data_held", 64'(out_data_o), 64'(prev_data));
        end
        if (hs) begin
            n_words++;
            if (exp_q.size() == 0) begin
                check("extra_word", 64'(out_data_o), 64'h0);
            end else begin
                check("word", 64'(out_data_o), 64'(exp_q.pop_front()));
            end
            if (chk_spacing) begin
                if (last_hs >= 0) check("spacing", 64'(cyc - last_hs), 64'd3);
                last_hs = cyc;
            end
        end
        if (done_o) begin
            n_done++;
            check("busy_at_done", 64'(busy_o), 64'd0);
        end
        prev_valid = out_valid_o;
        prev_data  = out_data_o;
        prev_hs    = hs;
        prev_kill  = rst || abort_i;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push the first n sweep entries (in order) onto the scoreboard.
    task automatic push_range(input int n);
        for (int i = 0; i < n; i++) begin
            int r;
            int a;
            r = i / NA;
            a = i % NA;
`ifdef RO_READOUT_SKIP_ZERO_EN
            if (!zero_mask[r]) exp_q.push_back(f_word(r, a, 1'b0));
`else
            exp_q.push_back(f_word(r, a, zero_mask[r]));
`endif
        end
    endtask

    task automatic start_and_check_first();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        check("valid_edge0", 64'(out_valid_o), 64'd0);
        tick(2);
        check("valid_edge2", 64'(out_valid_o), 64'd0);
        tick(1);
        check("valid_edge3", 64'(out_valid_o), 64'd1);
        check("first_word", 64'(out_data_o), 64'(f_word(0, 0, zero_mask[0])));
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            tick(1);
            if (done_o) got = 1'b1;
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic wait_addr(input int r, input int a, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            tick(1);
            if (int'(addr_o[r*AW +: AW]) == a && !out_valid_o) got = 1'b1;
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic wait_valid_tag(input int r, input int a, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            tick(1);
            if (out_valid_o && out_data_o[OW-1:DW] == {5'(r), 5'(a)}) got = 1'b1;
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic end_sweep(input int exp_words, input int done_before);
        check("word_count", 64'(n_words), 64'(exp_words));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        tick(4);
        check("done_count", 64'(n_done - done_before), 64'd1);
        check("idle_busy", 64'(busy_o), 64'd0);
        check("idle_valid", 64'(out_valid_o), 64'd0);
        check("idle_addr", 64'(addr_o), 64'd0);
    endtask

    initial begin
        int d0;
        logic [OW-1:0] held;
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; out_ready_i = 1'b0; zero_mask = '0;
        tick(3);
        check("rst_addr", 64'(addr_o), 64'd0);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_data", 64'(out_data_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        rst = 1'b0;
        tick(2);

        // Full sweep with ready always high, fixed 3-cycle spacing.
        out_ready_i = 1'b1;
        n_words = 0; d0 = n_done; last_hs = -1; chk_spacing = 1'b1;
        push_range(NR*NA);
        start_and_check_first();
        wait_done("done_full");
        chk_spacing = 1'b0;
        end_sweep(NR*NA, d0);

        // Backpressure at (3,4), then a stray start at (5,0).
        n_words = 0; d0 = n_done;
        push_range(NR*NA);
        start_and_check_first();
        wait_addr(3, 4, "reach_3_4");
        out_ready_i = 1'b0;
        wait_valid_tag(3, 4, "valid_3_4");
        held = out_data_o;
        check("held_word", 64'(held), 64'(f_word(3, 4, 1'b0)));
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("stall_valid", 64'(out_valid_o), 64'd1);
            check("stall_data", 64'(out_data_o), 64'(held));
        end
        out_ready_i = 1'b1;
        wait_valid_tag(5, 0, "valid_5_0");
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        wait_done("done_bp");
        end_sweep(NR*NA, d0);

        // Abort while (8,2) is held, then restart from (0,0).
        n_words = 0; d0 = n_done;
        push_range(8*NA + 2);
        start_and_check_first();
        wait_addr(8, 2, "reach_8_2");
        out_ready_i = 1'b0;
        wait_valid_tag(8, 2, "valid_8_2");
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        check("abort_valid", 64'(out_valid_o), 64'd0);
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_addr", 64'(addr_o), 64'd0);
        out_ready_i = 1'b1;
        tick(6);
        check("abort_words", 64'(n_words), 64'(8*NA + 2));
        check("abort_queue", 64'(exp_q.size()), 64'd0);
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        n_words = 0;
        push_range(NR*NA);
        start_and_check_first();
        wait_done("done_restart");
        end_sweep(NR*NA, d0);

        // Reset during SETTLE of (10,7), then a clean sweep.
        n_words = 0; d0 = n_done;
        push_range(10*NA + 7);
        start_and_check_first();
        wait_addr(10, 7, "reach_10_7");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mrst_addr", 64'(addr_o), 64'd0);
        check("mrst_valid", 64'(out_valid_o), 64'd0);
        check("mrst_data", 64'(out_data_o), 64'd0);
        check("mrst_busy", 64'(busy_o), 64'd0);
        check("mrst_done", 64'(done_o), 64'd0);
        check("mrst_queue", 64'(exp_q.size()), 64'd0);
        n_words = 0;
        push_range(NR*NA);
        start_and_check_first();
        wait_done("done_after_rst");
        end_sweep(NR*NA, d0);

        // Regions 2 and 16 read all-zero.
        zero_mask = '0;
        zero_mask[2] = 1'b1;
        zero_mask[16] = 1'b1;
        n_words = 0; d0 = n_done;
        push_range(NR*NA);
        start_and_check_first();
        wait_done("done_zero");
`ifdef RO_READOUT_SKIP_ZERO_EN
        end_sweep((NR - 2)*NA, d0);
`else
        end_sweep(NR*NA, d0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
